rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, read-port count.
REQ-004 SHALL have parameter MAX_PEND, default 3, outstanding reservations per register (1..7).
REQ-005 SHALL define AW = clog2(NUM_REGS) and CW = clog2(MAX_PEND+1).
REQ-006 Port clk  input  1  clock; all state updates on posedge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port rd_addr  input  NUM_RD*AW  read addresses, port i at [i*AW +: AW].
REQ-009 Port rd_data  output  NUM_RD*XLEN  read data per port.
REQ-010 Port rd_busy  output  NUM_RD  source still has pending writes, per port.
REQ-011 Port issue_valid  input  1  issuing instruction requests a destination reservation.
REQ-012 Port issue_dest  input  AW  destination to reserve.
REQ-013 Port issue_ready  output  1  reservation can be accepted this cycle.
REQ-014 Port wb_valid  input  1  writeback this cycle; always accepted.
REQ-015 Port wb_addr  input  AW  writeback destination.
REQ-016 Port wb_data  input  XLEN  writeback value.
REQ-017 Port err  output  1  sticky protocol-error flag.

Function
REQ-018 Register 0 SHALL read 0, never report busy, ignore writes, and never count reservations; issue to dest 0 is always ready.
REQ-019 Each register SHALL hold a CW-bit pending counter.
REQ-020 issue_ready SHALL be combinational: counter[issue_dest] != MAX_PEND, or issue_dest == 0.
REQ-021 Reservation accepted iff issue_valid & issue_ready; counter increments at next edge.
REQ-022 wb_valid SHALL write wb_data to wb_addr and decrement its counter at next edge.
REQ-023 Accepted reservation and writeback to the same register in one cycle SHALL leave its counter unchanged; data still written.
REQ-024 Writeback to a register whose counter is 0 (nonzero addr) SHALL write data, leave the counter at 0, and set err at next edge.
REQ-025 Counters SHALL never wrap: saturation is prevented by issue_ready and underflow by REQ-024.
REQ-026 rd_busy[i] SHALL be (counter[rd_addr_i] != 0), subject to REQ-030.
REQ-027 rd_data[i] SHALL be combinational from the register array, subject to REQ-030.
REQ-028 Reads SHALL use pre-edge state: a same-cycle reservation does not set busy until the next cycle.
REQ-029 Without bypass, write-to-read latency SHALL be 1 cycle; busy clears the cycle after the final writeback.

Reset
REQ-030 While reset is high at an edge: all counters 0, all registers 0, err 0; issue and wb in that cycle are discarded. Outputs after reset: rd_data 0, rd_busy 0, issue_ready 1, err 0.
REQ-031 Reset mid-operation SHALL drop all outstanding reservations; later writebacks then follow REQ-024.

Configuration
REQ-032 Macro RF_SCOREBOARD_BYPASS_EN: when defined, if wb_valid, wb_addr == rd_addr_i != 0 and counter == 1 with no same-cycle reservation of that register, rd_busy[i] = 0 and rd_data[i] = wb_data in the same cycle (0-cycle latency).
REQ-033 When undefined, no bypass logic exists and REQ-029 applies.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the opcode constants (OP_LOAD, OP_STORE, OP_ARITH, OP_BRANCH) and the default XLEN/NUM_REGS localparams.
REQ-035 Per-register pending logic SHALL be sub-module sb_pend_counter (inc, dec, count, full, empty), instantiated NUM_REGS-1 times.

Verification
REQ-036 Reset, then read x5 and x0 -> rd_data 0, rd_busy 0, issue_ready 1, err 0.
REQ-037 Issue dest 5 at cycle 0, wb x5=0xDEADBEEF at cycle 3 -> busy cycles 1-3, cleared cycle 4 with data 0xDEADBEEF. With BYPASS_EN, cleared with data in cycle 3.
REQ-038 Reserve x7 MAX_PEND(3) times -> issue_ready 0 for dest 7, still 1 for dest 8; one wb to x7 -> ready 1 next cycle.
REQ-039 Same-cycle issue x9 and wb x9=0x11 with counter 1 -> counter stays 1, busy held, data 0x11 visible next cycle.
REQ-040 wb x4=0x22 with counter 0 -> x4 reads 0x22, err 1 and remains 1 until reset.
REQ-041 Reserve x3 twice, assert reset, then wb x3 -> counter 0, err 1, x3 not busy.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: opcode encodings and default register-file geometry.
package pipe_pkg;
  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_STORE  = 2'd1;
  localparam logic [1:0] OP_ARITH  = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_NUM_REGS = 32;
endpackage

// File: rtl/sb_pend_counter.sv
// Per-register outstanding-write counter: saturation is the caller's job via full,
// underflow is blocked here so an unmatched writeback leaves the count at zero.
module sb_pend_counter #(
  parameter int MAX_PEND = 3,
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PEND);

  assign full  = (count == MAXC);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write scoreboard and sticky protocol error.
// Optional same-cycle writeback-to-read forwarding under RF_SCOREBOARD_BYPASS_EN.
module rf_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NUM_RD   = 2,
  parameter int MAX_PEND = 3,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_dest,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   err
);
  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [CW-1:0]       cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] empty;
  logic [NUM_REGS-1:0] inc;
  logic                issue_acc;

  assign issue_ready = (issue_dest == '0) || !full[issue_dest];
  assign issue_acc   = issue_valid && issue_ready;
  assign inc         = issue_acc ? (NUM_REGS'(1) << issue_dest) : '0;

  // x0 has no counter: permanently idle and never full
  assign cnt[0]   = '0;
  assign full[0]  = 1'b0;
  assign empty[0] = 1'b1;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    sb_pend_counter #(.MAX_PEND(MAX_PEND), .CW(CW)) u_pend (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[r]),
      .dec   (wb_valid && (wb_addr == AW'(r))),
      .count (cnt[r]),
      .full  (full[r]),
      .empty (empty[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wb_valid && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A writeback paired with a same-cycle reservation of the same register is not an underflow
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (wb_valid && (wb_addr != '0) && (cnt[wb_addr] == '0) && !inc[wb_addr]) begin
      err <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
`ifdef RF_SCOREBOARD_BYPASS_EN
    logic byp;
    assign byp = wb_valid && (wb_addr == a) && (a != '0) && (cnt[a] == CW'(1)) && !inc[a];
    assign rd_busy[p]              = !empty[a] && !byp;
    assign rd_data[p*XLEN +: XLEN] = byp ? wb_data : regs[a];
`else
    assign rd_busy[p]              = !empty[a];
    assign rd_data[p*XLEN +: XLEN] = regs[a];
`endif
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed plus random bench for rf_scoreboard against a behavioural scoreboard model.
module tb_rf_scoreboard;
  localparam int NR = 32, XL = 32, NRD = 2, MP = 3, AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XL-1:0] rd_data;
  logic [NRD-1:0]  rd_busy;
  logic            issue_valid, issue_ready, wb_valid, err;
  logic [AW-1:0]   issue_dest, wb_addr;
  logic [XL-1:0]   wb_data;

  int errors = 0;
  int checks = 0;

  int          pend_m [NR];
  logic [XL-1:0] val_m [NR];
  bit          err_m;

  rf_scoreboard #(.NUM_REGS(NR), .XLEN(XL), .NUM_RD(NRD), .MAX_PEND(MP)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check pre-edge outputs against the model, then advance the model.
  task automatic cycle(input bit rst, input bit iv, input int idest, input bit wv,
                       input int waddr, input logic [XL-1:0] wdata, input int ra0, input int ra1);
    int ra [NRD];
    bit acc, rdy, byp;
    logic [XL-1:0] ed;
    ra[0] = ra0; ra[1] = ra1;
    @(negedge clk);
    reset = rst; issue_valid = iv; issue_dest = AW'(idest);
    wb_valid = wv; wb_addr = AW'(waddr); wb_data = wdata;
    rd_addr = {AW'(ra1), AW'(ra0)};
    #1;
    rdy = (idest == 0) || (pend_m[idest] < MP);
    acc = iv && rdy;
    if (!rst) begin
      chk("issue_ready", issue_ready, rdy);
      chk("err", err, err_m);
      for (int p = 0; p < NRD; p++) begin
        byp = 1'b0;
`ifdef RF_SCOREBOARD_BYPASS_EN
        byp = wv && waddr == ra[p] && ra[p] != 0 && pend_m[ra[p]] == 1 && !(acc && idest == ra[p]);
`endif
        ed = byp ? wdata : (ra[p] == 0 ? '0 : val_m[ra[p]]);
        chk($sformatf("rd_busy%0d_x%0d", p, ra[p]), rd_busy[p], (ra[p] != 0 && pend_m[ra[p]] > 0 && !byp));
        chk($sformatf("rd_data%0d_x%0d", p, ra[p]), rd_data[p*XL +: XL], ed);
      end
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NR; r++) begin pend_m[r] = 0; val_m[r] = '0; end
      err_m = 1'b0;
    end else begin
      if (wv && waddr != 0) val_m[waddr] = wdata;
      if (acc && idest != 0 && wv && waddr == idest) begin
        // reservation and retirement cancel out
      end else begin
        if (acc && idest != 0) pend_m[idest]++;
        if (wv && waddr != 0) begin
          if (pend_m[waddr] == 0) err_m = 1'b1;
          else pend_m[waddr]--;
        end
      end
    end
  endtask

  task automatic idle(input int ra0, input int ra1);
    cycle(0, 0, 0, 0, 0, '0, ra0, ra1);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin pend_m[r] = 0; val_m[r] = '0; end
    err_m = 1'b0;
    reset = 1'b1; issue_valid = 0; issue_dest = '0; wb_valid = 0; wb_addr = '0;
    wb_data = '0; rd_addr = '0;

    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    // reset state: x5 and x0 idle and zero
    idle(5, 0);
    chk("rst_data5", rd_data[XL-1:0], 32'h0);
    chk("rst_busy", rd_busy, 2'b00);
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_err", err, 1'b0);

    // single reservation of x5, retired in cycle 3
    cycle(0, 1, 5, 0, 0, '0, 5, 0);
    idle(5, 0);
    chk("x5_busy_c1", rd_busy[0], 1'b1);
    idle(5, 0);
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 5);
    idle(5, 0);
    chk("x5_data_c4", rd_data[XL-1:0], 32'hDEADBEEF);
    chk("x5_busy_c4", rd_busy[0], 1'b0);

    // saturate x7, x8 remains available, one retirement frees a slot
    for (int k = 0; k < MP; k++) cycle(0, 1, 7, 0, 0, '0, 7, 8);
    cycle(0, 1, 7, 0, 0, '0, 7, 8);
    chk("x7_full_ready", issue_ready, 1'b0);
    cycle(0, 1, 8, 0, 0, '0, 7, 8);
    cycle(0, 0, 7, 1, 7, 32'h77, 7, 8);
    cycle(0, 0, 7, 0, 0, '0, 7, 8);
    chk("x7_ready_after_wb", issue_ready, 1'b1);

    // same-cycle issue and writeback on x9 with one pending
    cycle(0, 1, 9, 0, 0, '0, 9, 0);
    cycle(0, 1, 9, 1, 9, 32'h11, 9, 0);
    idle(9, 0);
    chk("x9_busy_held", rd_busy[0], 1'b1);
    chk("x9_data", rd_data[XL-1:0], 32'h11);

    // unmatched writeback to x4 raises sticky err
    cycle(0, 0, 0, 1, 4, 32'h22, 4, 0);
    idle(4, 0);
    chk("x4_data", rd_data[XL-1:0], 32'h22);
    chk("err_set", err, 1'b1);
    idle(4, 0);
    chk("err_sticky", err, 1'b1);

    // reservations dropped by reset; later writeback is a protocol error
    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    cycle(0, 1, 3, 0, 0, '0, 3, 0);
    cycle(0, 1, 3, 0, 0, '0, 3, 0);
    cycle(1, 1, 3, 1, 3, 32'h5, 3, 0);
    cycle(0, 0, 0, 1, 3, 32'h33, 3, 0);
    idle(3, 0);
    chk("x3_not_busy", rd_busy[0], 1'b0);
    chk("x3_err", err, 1'b1);

    // random traffic; writebacks usually target a pending register
    for (int n = 0; n < 600; n++) begin
      int d, w, a0, a1;
      bit iv, wv, rs;
      d  = $urandom_range(0, 9);
      iv = ($urandom_range(0, 2) != 0);
      wv = ($urandom_range(0, 1) != 0);
      w  = $urandom_range(0, 9);
      if ($urandom_range(0, 7) != 0) begin
        for (int t = 0; t < 10; t++) begin
          int c;
          c = $urandom_range(1, 9);
          if (pend_m[c] > 0) begin w = c; break; end
        end
      end
      a0 = $urandom_range(0, 9);
      a1 = (($urandom_range(0, 1) != 0) ? w : $urandom_range(0, NR - 1));
      rs = ($urandom_range(0, 150) == 0);
      cycle(rs, iv, d, wv, w, $urandom, a0, a1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
